mul_approx_seq: RTL
===================

MUL_APPROX_SEQ -- requirements
Module: mul_approx_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits; legal range 2..16.
REQ-002 SHALL have parameter TRUNC, default 4, number of low product columns dropped in approximate mode; legal range 0..2*WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands and mode are presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-008 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-009 SHALL have port approx  input  1  1 = truncated product, 0 = exact product.
REQ-010 SHALL have port out_valid  output  1  product is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port product  output  2*WIDTH  unsigned result.
REQ-013 SHALL have port approx_o  output  1  mode used for the current product.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept: in IDLE with in_valid=1, SHALL latch a, b and approx, clear accumulator and row counter to 0, go to RUN.
REQ-016 RUN: each cycle SHALL add row r = (b[r] ? a<<r : 0), masked per REQ-018, to the accumulator, then increment r.
REQ-017 After the row r = WIDTH-1 add, SHALL go to DONE; out_valid rises exactly WIDTH rising edges after the accept edge.
REQ-018 Approximate mode: partial-product bit a[i]&b[j] with i+j < TRUNC SHALL be discarded before accumulation; product[TRUNC-1:0] is therefore 0. Exact mode: no masking.
REQ-019 Accumulator SHALL be 2*WIDTH bits; overflow impossible, no saturation or wrap logic.
REQ-020 DONE: product and approx_o SHALL hold stable while out_valid=1 and out_ready=0 (back-pressure held indefinitely).
REQ-021 DONE with out_ready=1: SHALL go to IDLE on that edge; no new accept in the same cycle (in_ready=0 in DONE).
REQ-022 in_valid during RUN or DONE SHALL be ignored; operand inputs changing during RUN SHALL not affect the result.
REQ-023 TRUNC=0 SHALL make approximate and exact results identical.
REQ-024 Approximate result SHALL never exceed exact result; error = exact - approx = sum of dropped bits.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, in_ready=1 on the next cycle, out_valid=0, product=0, approx_o=0, row counter=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no out_valid pulse follows for the aborted operands.
REQ-027 in_valid asserted in the same cycle as rst_n=0 SHALL not be accepted.

Verification (WIDTH=6, TRUNC=4)
REQ-028 a=63, b=63, approx=0 -> out_valid 6 cycles after accept, product=3969.
REQ-029 a=63, b=63, approx=1 -> product=3920 (49 dropped), product[3:0]=0, approx_o=1.
REQ-030 a=5, b=3, approx=1 -> product=0; same operands approx=0 -> product=15.
REQ-031 a=32, b=32 both modes -> product=1024; a=0, b=63 -> product=0.
REQ-032 out_ready held 0 for 10 cycles in DONE -> product/out_valid stable, in_ready=0; in_valid pulsed meanwhile -> ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst_n=0 on RUN cycle 3 -> IDLE, out_valid never asserts for that operand; next accept a=7, b=9, approx=0 -> product=63.

Source files
------------

// File: rtl/mul_approx_seq.sv
// Shift-add multiplier (one partial-product row per cycle) with optional column truncation.
// Result appears WIDTH cycles after accept and is held in DONE until out_ready; in_ready only in IDLE.
module mul_approx_seq #(
  parameter int WIDTH = 6,
  parameter int TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               approx_o
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bit a[i]&b[j] lands in column i+j, so dropping columns below TRUNC drops exactly those terms.
  localparam logic [PW-1:0] APPROX_KEEP = {PW{1'b1}} << TRUNC;
  localparam logic [RW-1:0] LAST_ROW    = RW'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             approx_q, approx_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [RW-1:0]    row_q,    row_d;
  logic [PW-1:0]    row_pp;

  always_comb begin
    row_pp = '0;
    if (b_q[row_q]) begin
      row_pp = PW'(a_q) << row_q;
    end
    if (approx_q) begin
      row_pp = row_pp & APPROX_KEEP;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    row_d    = row_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          approx_d = approx;
          acc_d    = '0;
          row_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + row_pp;
        row_d = row_q + RW'(1);
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      row_q    <= row_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = acc_q;
  assign approx_o  = approx_q;

endmodule
